hazard_unit: RTL
================

Name: hazard_unit

Overview:
Hazard-resolution controller for the 5-stage RISC-V pipeline. It is the counterpart to the execute-stage forwarding logic and handles every hazard that bypassing cannot cover:
- load-use dependencies (stall plus bubble),
- taken branches and jumps (flush),
- multi-cycle data-memory accesses (whole-pipe freeze through a ready handshake).
It also keeps a memory-wait FSM with timeout detection and saturating hazard event counters for performance analysis.

Parameters:
REG_ADDR_W, 5, register index width
CNT_W, 16, width of each saturating event counter
MEM_TIMEOUT, 64, maximum consecutive memory-wait cycles before the error flag is set (>=1)

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
rs1_D  input  REG_ADDR_W  decode-stage source register 1
rs2_D  input  REG_ADDR_W  decode-stage source register 2
rd_E  input  REG_ADDR_W  execute-stage destination register
MemRead_E  input  1  execute-stage instruction is a load
PCSrc_E  input  1  execute-stage branch taken or jump resolved
MemReq_M  input  1  memory-stage instruction accesses data memory
mem_ready_M  input  1  data memory completes the access this cycle
Stall_F  output  1  hold PC
Stall_D  output  1  hold IF/ID register
Stall_E  output  1  hold ID/EX register
Stall_M  output  1  hold EX/MEM register
Flush_D  output  1  clear IF/ID register
Flush_E  output  1  clear ID/EX register
Flush_W  output  1  clear MEM/WB register (bubble into writeback)
PCSrc_F  output  1  gated PC redirect select
mem_timeout_err  output  1  sticky memory-timeout flag
load_use_cnt  output  CNT_W  count of load-use stall events
flush_cnt  output  CNT_W  count of branch flush events
mem_wait_cnt  output  CNT_W  count of memory-freeze cycles

Behaviour:
- Derived terms, combinational, same cycle:
  - mem_stall = MemReq_M & ~mem_ready_M
  - lu_hz = MemRead_E & (rd_E != 0) & (rd_E == rs1_D | rd_E == rs2_D)
  - br = PCSrc_E
- Priority (highest first):
  1. mem_stall: Stall_F = Stall_D = Stall_E = Stall_M = 1, Flush_W = 1. All other controls are 0 and PCSrc_F = 0, so the redirect is deferred. The frozen E stage keeps PCSrc_E valid until release.
  2. br: Flush_D = Flush_E = 1, PCSrc_F = 1, all stalls 0.
  3. lu_hz: Stall_F = Stall_D = 1, Flush_E = 1, for exactly 1 cycle per dependency. The next cycle the load is in M and is forwarded.
  4. Otherwise every control output is 0.
- br and lu_hz cannot legitimately coexist, because a load never resolves PCSrc_E. If both are asserted, br wins.
- The release cycle (mem_ready_M = 1) has no stall. Any pending br or lu_hz takes effect in that same cycle.
- Memory FSM, registered:
  - IDLE -> WAIT when mem_stall.
  - WAIT -> IDLE when mem_ready_M, or when MemReq_M drops (an abandoned request is treated as complete).
  - wait_ctr resets to 0 on entry to WAIT and increments each WAIT cycle, saturating at MEM_TIMEOUT.
  - When wait_ctr reaches MEM_TIMEOUT while still in WAIT, mem_timeout_err is set. It is sticky until reset.
  - The FSM never forces a release. Stalls track mem_stall only.
- Counters, all saturating at 2^CNT_W-1 with no wrap:
  - load_use_cnt +1 per cycle in which priority 3 is active.
  - flush_cnt +1 per cycle in which priority 2 is active.
  - mem_wait_cnt +1 per cycle with mem_stall.
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; wait_ctr, all counters and mem_timeout_err go to 0.
  - While rst_n is low, every stall, flush and PCSrc_F output is forced to 0.
  - Reset mid-WAIT aborts the wait. After release, the FSM re-evaluates from IDLE.
- A destination register of 0 never causes a hazard.

Decomposition:
- Shared package hazard_pkg:
  - REG_ADDR_W default;
  - the enum mem_state_t {MEM_IDLE, MEM_WAIT};
  - a struct hazard_ctrl_t bundling the seven stall/flush bits for pipeline-register consumers.
- Sub-module sat_counter (parameter W; ports inc, value) is instantiated three times.
- The priority logic and the FSM stay in hazard_unit.

Test Plan:
1. MemRead_E=1, rd_E=5, rs1_D=5, rs2_D=3 -> that cycle Stall_F=Stall_D=Flush_E=1, Stall_E=0. Next cycle (MemRead_E=0) all 0. load_use_cnt=1.
2. MemRead_E=1, rd_E=0, rs1_D=0 -> no stall or flush. load_use_cnt stays 0.
3. PCSrc_E=1 for 1 cycle -> Flush_D=Flush_E=1, PCSrc_F=1, stalls 0. flush_cnt=1.
4. MemReq_M=1, mem_ready_M=0 for 3 cycles then 1 -> stalls F/D/E/M and Flush_W=1 for exactly 3 cycles; FSM in WAIT for cycles 2-4 and IDLE after; mem_wait_cnt=3; 0 in the ready cycle.
5. mem_stall for 2 cycles with PCSrc_E=1 throughout -> PCSrc_F=0 and Flush_D/E=0 for those 2 cycles. In the ready cycle, PCSrc_F=1 and Flush_D=Flush_E=1.
6. MEM_TIMEOUT=4: hold mem_ready_M=0 for 6 cycles -> mem_timeout_err rises after the 4th WAIT cycle and stays 1 after ready. Then pulse rst_n low mid-cycle -> err=0, counters=0, FSM IDLE, all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard-resolution controller.
// No logic, so no latency.
// No flow control.
package hazard_pkg;

    // Default widths and limits. Instances may override them through module parameters.
    localparam int DEF_REG_ADDR_W  = 5;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_MEM_TIMEOUT = 64;

    // Memory-wait tracker state.
    // MEM_WAIT means that the previous cycle froze the pipe on a data-memory access.
    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    // The seven hold/clear strobes that go to the PC and to the pipeline registers.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } hazard_ctrl_t;

    localparam hazard_ctrl_t CTRL_NONE = '{default: 1'b0};

    // Returns 1 when a load in execute writes a register that decode reads.
    // x0 is hard-wired to zero, so a load into x0 never creates a dependency.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [7:0] rd,
        input logic [7:0] rs1,
        input logic [7:0] rs2
    );
        return mem_read && (rd != 8'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: it counts up by one on each cycle where inc is high and stops at all-ones.
// Latency: the count shows the change one cycle after inc.
// No backpressure. An inc pulse that arrives while the counter is saturated is dropped.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Compute the next count. The counter holds at its maximum value and does not wrap.
    always_comb begin
        value_d = value_q;
        if (inc && (value_q != MAX_VAL)) begin
            value_d = value_q + 1'b1;
        end
    end

    // Count register. It clears at once when reset goes low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/hazard_unit.sv
// Resolves pipeline hazards: it freezes the pipe during memory waits, flushes on a taken branch and stalls on a load-use dependency.
// Latency: the control outputs are combinational in the same cycle. The error flag and counters update one cycle later.
// Backpressure: mem_ready_M low with MemReq_M high freezes F/D/E/M and inserts a bubble into W until the access completes.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_D,
    input  logic [REG_ADDR_W-1:0] rs2_D,
    input  logic [REG_ADDR_W-1:0] rd_E,
    input  logic                  MemRead_E,
    input  logic                  PCSrc_E,
    input  logic                  MemReq_M,
    input  logic                  mem_ready_M,
    output logic                  Stall_F,
    output logic                  Stall_D,
    output logic                  Stall_E,
    output logic                  Stall_M,
    output logic                  Flush_D,
    output logic                  Flush_E,
    output logic                  Flush_W,
    output logic                  PCSrc_F,
    output logic                  mem_timeout_err,
    output logic [CNT_W-1:0]      load_use_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      mem_wait_cnt
);

    // The wait counter must be able to hold MEM_TIMEOUT itself.
    localparam int                WCTR_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCTR_W-1:0] TIMEOUT_C = WCTR_W'(MEM_TIMEOUT);

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic mem_stall;
    logic lu_hz;
    logic br;

    // Classify this cycle's hazards from the decode, execute and memory stage fields.
    always_comb begin
        mem_stall = MemReq_M & ~mem_ready_M;
        br        = PCSrc_E;
        lu_hz     = load_use_hit(MemRead_E,
                                 8'(rd_E),
                                 8'(rs1_D),
                                 8'(rs2_D));
    end

    // ------------------------------------------------------------------
    // Priority resolution
    // ------------------------------------------------------------------
    hazard_ctrl_t ctrl;
    logic         pcsrc_raw;
    logic         br_act;
    logic         lu_act;

    // A memory freeze beats a redirect, and a redirect beats a load-use bubble.
    // During a freeze the redirect waits, because the frozen E stage keeps PCSrc_E asserted until the release cycle.
    always_comb begin
        ctrl      = CTRL_NONE;
        pcsrc_raw = 1'b0;
        br_act    = 1'b0;
        lu_act    = 1'b0;
        if (mem_stall) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.stall_e = 1'b1;
            ctrl.stall_m = 1'b1;
            ctrl.flush_w = 1'b1;
        end else if (br) begin
            ctrl.flush_d = 1'b1;
            ctrl.flush_e = 1'b1;
            pcsrc_raw    = 1'b1;
            br_act       = 1'b1;
        end else if (lu_hz) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.flush_e = 1'b1;
            lu_act       = 1'b1;
        end
    end

    // While reset is low, every pipeline control is held at 0 regardless of the inputs.
    assign Stall_F = rst_n & ctrl.stall_f;
    assign Stall_D = rst_n & ctrl.stall_d;
    assign Stall_E = rst_n & ctrl.stall_e;
    assign Stall_M = rst_n & ctrl.stall_m;
    assign Flush_D = rst_n & ctrl.flush_d;
    assign Flush_E = rst_n & ctrl.flush_e;
    assign Flush_W = rst_n & ctrl.flush_w;
    assign PCSrc_F = rst_n & pcsrc_raw;

    // ------------------------------------------------------------------
    // Memory-wait tracker and timeout detection
    // ------------------------------------------------------------------
    mem_state_t        state_q;
    mem_state_t        state_d;
    logic [WCTR_W-1:0] wait_ctr_q;
    logic [WCTR_W-1:0] wait_ctr_d;
    logic              err_q;
    logic              err_d;

    // Track how long the memory has held the pipe.
    // A request that is dropped counts as complete. The tracker only observes and never releases the pipe itself.
    always_comb begin
        state_d    = state_q;
        wait_ctr_d = wait_ctr_q;
        err_d      = err_q;
        unique case (state_q)
            MEM_IDLE: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_ctr_d = '0;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d = MEM_IDLE;
                end else begin
                    if (wait_ctr_q != TIMEOUT_C) begin
                        wait_ctr_d = wait_ctr_q + 1'b1;
                    end
                    if (wait_ctr_d == TIMEOUT_C) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = MEM_IDLE;
                wait_ctr_d = '0;
            end
        endcase
    end

    // Tracker registers. Reset abandons any wait in progress and clears the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MEM_IDLE;
            wait_ctr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_ctr_q <= wait_ctr_d;
            err_q      <= err_d;
        end
    end

    assign mem_timeout_err = err_q;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    sat_counter #(.W(CNT_W)) u_load_use_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lu_act),
        .value (load_use_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_act),
        .value (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mem_stall),
        .value (mem_wait_cnt)
    );

endmodule
